// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the data-memory channel arbiter.
package mem_arb_pkg;

   typedef enum logic [2:0] {
      ST_IDLE          = 3'd0,
      ST_READ_WAIT     = 3'd1,
      ST_WRITE_WAIT    = 3'd2,
      ST_READ_RELEASE  = 3'd3,
      ST_WRITE_RELEASE = 3'd4
   } arb_state_t;

   // Width of a requester index; never narrower than one bit.
   function automatic int grant_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set request at or after rr_ptr, wrapping.
module rr_picker #(
   parameter int N  = 4,
   parameter int IW = 2
) (
   input  logic [N-1:0]  request,
   input  logic [IW-1:0] rr_ptr,
   output logic          found,
   output logic [IW-1:0] index
);

   // Scan from the far end back toward rr_ptr so the closest hit is written last.
   always_comb begin
      logic [IW-1:0] pos;
      pos   = '0;
      found = 1'b0;
      index = '0;
      for (int k = N - 1; k >= 0; k--) begin
         pos = IW'((int'(rr_ptr) + k) % N);
         if (request[pos]) begin
            found = 1'b1;
            index = pos;
         end
      end
   end

endmodule

// File: rtl/mem_channel_arbiter.sv
// Round-robin arbiter sharing one read/write data-memory channel among LSU ports.
// Handshake: a valid is held until its ready rises; ready is held until that valid drops.
module mem_channel_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_BITS      = 8,
   parameter int DATA_BITS      = 8,
   parameter int NUM_REQUESTERS = 4,
   parameter int WRITE_ENABLE   = 1,
   localparam int GRANT_BITS    = grant_width(NUM_REQUESTERS)
) (
   input  logic                                     clk,
   input  logic                                     reset,
   input  logic [NUM_REQUESTERS-1:0]                req_read_valid,
   input  logic [NUM_REQUESTERS-1:0][ADDR_BITS-1:0] req_read_address,
   output logic [NUM_REQUESTERS-1:0]                req_read_ready,
   output logic [NUM_REQUESTERS-1:0][DATA_BITS-1:0] req_read_data,
   input  logic [NUM_REQUESTERS-1:0]                req_write_valid,
   input  logic [NUM_REQUESTERS-1:0][ADDR_BITS-1:0] req_write_address,
   input  logic [NUM_REQUESTERS-1:0][DATA_BITS-1:0] req_write_data,
   output logic [NUM_REQUESTERS-1:0]                req_write_ready,
   output logic                                     mem_read_valid,
   output logic [ADDR_BITS-1:0]                     mem_read_address,
   input  logic                                     mem_read_ready,
   input  logic [DATA_BITS-1:0]                     mem_read_data,
   output logic                                     mem_write_valid,
   output logic [ADDR_BITS-1:0]                     mem_write_address,
   output logic [DATA_BITS-1:0]                     mem_write_data,
   input  logic                                     mem_write_ready,
   output logic                                     busy,
   output logic [GRANT_BITS-1:0]                    grant_id,
   output logic [2:0]                               arb_state
);

   arb_state_t                state;
   logic [GRANT_BITS-1:0]     gsel;
   logic [GRANT_BITS-1:0]     rr_ptr;
   logic [GRANT_BITS-1:0]     pick_index;
   logic [GRANT_BITS-1:0]     next_ptr;
   logic                      pick_found;
   logic                      write_en;
   logic [NUM_REQUESTERS-1:0] candidate;

   assign write_en  = (WRITE_ENABLE != 0);
   assign candidate = (req_read_valid | (req_write_valid & {NUM_REQUESTERS{write_en}}))
                      & ~req_read_ready & ~req_write_ready;
   assign next_ptr  = (pick_index == GRANT_BITS'(NUM_REQUESTERS - 1)) ? '0
                      : pick_index + GRANT_BITS'(1);
   assign arb_state = state;

   rr_picker #(
      .N  (NUM_REQUESTERS),
      .IW (GRANT_BITS)
   ) u_picker (
      .request (candidate),
      .rr_ptr  (rr_ptr),
      .found   (pick_found),
      .index   (pick_index)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         state             <= ST_IDLE;
         gsel              <= '0;
         rr_ptr            <= '0;
         grant_id          <= '0;
         busy              <= 1'b0;
         mem_read_valid    <= 1'b0;
         mem_read_address  <= '0;
         mem_write_valid   <= 1'b0;
         mem_write_address <= '0;
         mem_write_data    <= '0;
         req_read_ready    <= '0;
         req_read_data     <= '0;
         req_write_ready   <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (pick_found) begin
                  gsel     <= pick_index;
                  grant_id <= pick_index;
                  rr_ptr   <= next_ptr;
                  busy     <= 1'b1;
                  // A port asking for both is served read first; its write waits for the next grant.
                  if (req_read_valid[pick_index]) begin
                     mem_read_valid   <= 1'b1;
                     mem_read_address <= req_read_address[pick_index];
                     state            <= ST_READ_WAIT;
                  end else begin
                     mem_write_valid   <= 1'b1;
                     mem_write_address <= req_write_address[pick_index];
                     mem_write_data    <= req_write_data[pick_index];
                     state             <= ST_WRITE_WAIT;
                  end
               end
            end
            ST_READ_WAIT: begin
               if (mem_read_ready) begin
                  mem_read_valid      <= 1'b0;
                  req_read_data[gsel]  <= mem_read_data;
                  req_read_ready[gsel] <= 1'b1;
                  state               <= ST_READ_RELEASE;
               end
            end
            ST_WRITE_WAIT: begin
               if (mem_write_ready) begin
                  mem_write_valid       <= 1'b0;
                  req_write_ready[gsel] <= 1'b1;
                  state                 <= ST_WRITE_RELEASE;
               end
            end
            ST_READ_RELEASE: begin
               if (!req_read_valid[gsel]) begin
                  req_read_ready[gsel] <= 1'b0;
                  busy                 <= 1'b0;
                  state                <= ST_IDLE;
               end
            end
            ST_WRITE_RELEASE: begin
               if (!req_write_valid[gsel]) begin
                  req_write_ready[gsel] <= 1'b0;
                  busy                  <= 1'b0;
                  state                 <= ST_IDLE;
               end
            end
            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/mem_channel_arbiter.md
Name: mem_channel_arbiter

Overview:
- Shares one data-memory channel (read and write) between NUM_REQUESTERS per-thread LSU ports.
- Uses round-robin grant.
- Sits between the core's LSU-facing data memory interface and the external data memory.
- Serves one transaction at a time using the codebase's valid/ready hold-until-released handshake.

Parameters:
- ADDR_BITS, 8, data memory address width
- DATA_BITS, 8, data memory word width
- NUM_REQUESTERS, 4, number of LSU ports arbitrated (≥2)
- WRITE_ENABLE, 1, 0 = read-only arbiter; write paths are ignored and their outputs are tied low

Ports:
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-low reset (reset==0 resets on the clock edge)
- req_read_valid  in  [NUM_REQUESTERS]  read request per requester
- req_read_address  in  [NUM_REQUESTERS][ADDR_BITS]  read address
- req_read_ready  out  [NUM_REQUESTERS]  read complete, data valid
- req_read_data  out  [NUM_REQUESTERS][DATA_BITS]  returned read data
- req_write_valid  in  [NUM_REQUESTERS]  write request
- req_write_address  in  [NUM_REQUESTERS][ADDR_BITS]  write address
- req_write_data  in  [NUM_REQUESTERS][DATA_BITS]  write data
- req_write_ready  out  [NUM_REQUESTERS]  write complete
- mem_read_valid  out  1  memory read request
- mem_read_address  out  ADDR_BITS  memory read address
- mem_read_ready  in  1  memory read done
- mem_read_data  in  DATA_BITS  memory read data
- mem_write_valid  out  1  memory write request
- mem_write_address  out  ADDR_BITS  memory write address
- mem_write_data  out  DATA_BITS  memory write data
- mem_write_ready  in  1  memory write done
- busy  out  1  high in any state other than IDLE
- grant_id  out  clog2(NUM_REQUESTERS)  current or last grantee

Behaviour:
- Reset: every output is 0, rr_ptr=0, state=IDLE. An in-flight memory access is abandoned; its later ready is ignored because the arbiter is in IDLE.
- All outputs are registered.
- States: IDLE, READ_WAIT, WRITE_WAIT, READ_RELEASE, WRITE_RELEASE.
- Candidate: requester i with (req_read_valid[i] | (WRITE_ENABLE & req_write_valid[i])) and its ready output low.
- IDLE grant:
  - Pick the first candidate scanning rr_ptr, rr_ptr+1, … with wrap mod N.
  - If the winner has both read and write valid, read is served first.
  - Latch g, the address, and the write data.
  - Set rr_ptr=(g+1) mod N and grant_id=g.
  - Next cycle mem_*_valid=1 (1-cycle issue latency); go to READ_WAIT or WRITE_WAIT.
- READ_WAIT:
  - Hold mem_read_valid and the address.
  - On mem_read_ready=1: clear mem_read_valid, set req_read_data[g]=mem_read_data, req_read_ready[g]=1, go to READ_RELEASE.
- WRITE_WAIT: same pattern. On mem_write_ready: clear mem_write_valid, req_write_ready[g]=1, go to WRITE_RELEASE.
- RELEASE:
  - Hold ready[g] and req_read_data[g] until the matching req_*_valid[g]==0.
  - Then clear ready[g] and go to IDLE.
  - No new grant is made in the same cycle; minimum turnaround is 1 IDLE cycle.
- req_read_data[i] is held between transactions until overwritten.
- A requester dropping valid during WAIT still has its memory access completed. Ready then pulses for exactly 1 cycle.
- mem ready arriving while the arbiter is not in WAIT is ignored.
- Fairness: a continuously requesting port waits at most N-1 transactions.

Decomposition:
- Package mem_arb_pkg: arb_state_t enum (the 5 states), and a function clog2-safe width for grant_id (minimum 1).
- Sub-module rr_picker (combinational):
  - Inputs: request vector, rr_ptr.
  - Outputs: found, index.
  - Reusable by a future multi-channel controller.

Test Plan:
- Single read: req 2 reads addr 0x3C at t0; mem_read_valid rises at t1 with address 0x3C; mem returns 0xA5 at t4 → req_read_ready[2]=1 with data 0xA5 at t5. Drop valid at t6 → ready 0 at t7, busy 0.
- Contention: all 4 ports read simultaneously, rr_ptr=0 → grant order 0,1,2,3. Immediately re-request port 0 → next grant is 0 only after 1–3 complete.
- Read+write same port: port 1 asserts read 0x10 and write 0x20/0x77 → read issued first. After release, write issued with mem_write_address=0x20 and mem_write_data=0x77.
- Reset mid-op: reset=0 during READ_WAIT → next edge all outputs 0 and state IDLE. A stale mem_read_ready after reset=1 produces no req_read_ready.
- WRITE_ENABLE=0: req_write_valid=1 on all ports → no mem_write_valid ever asserted, busy stays 0, and reads still arbitrate.
- Early valid drop: port 3 drops read valid during READ_WAIT → memory access completes and req_read_ready[3] is high for exactly 1 cycle.
